// File: rtl/irq_pic.sv
// irq_pic -- programmable interrupt controller feeding the CPU irq bus.
//
// Peripheral requests are synchronised (s1, s2), edge-detected against a
// history flop (s3) and latched into a per-channel pending register.
// Software reaches the controller through a small request/ack register bus:
//   0 PEND    R: pending bits          W: write-1-to-clear
//   1 MASK    RW, 1 = channel masked
//   2 EDGE    RW, 1 = edge-triggered, 0 = level
//   3 SET     R: synchronised sources  W: OR into pending
//   4 COUNT   timer count   (timer build only, else reads 0)
//   5 COMPARE timer compare (timer build only, else reads 0)
//   6,7       read 0, writes ignored
//
// Optional feature: define IRQ_PIC_TIMER_EN to add a 32-bit count/compare
// timer that owns the top channel (IRQ_CH-1) in place of its external source.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   src[IRQ_CH]         raw asynchronous peripheral requests
//   bus_req/rw/addr     register access; req held until bus_ack
//   bus_wr_data         write data
//   bus_rd_data         read data, valid while bus_ack = 1
//   bus_ack             one-cycle access-complete pulse
//   irq[IRQ_CH]         registered pend & ~mask
//   irq_id              lowest-numbered asserted irq channel (IRQ_CH <= 8)
//   irq_any             OR of irq

module irq_pic #(
  parameter int IRQ_CH = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] src,
  input  logic              bus_req,
  input  logic              bus_rw,
  input  logic [2:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic [DATA_W-1:0] bus_rd_data,
  output logic              bus_ack,
  output logic [IRQ_CH-1:0] irq,
  output logic [2:0]        irq_id,
  output logic              irq_any
);

  localparam logic [IRQ_CH-1:0] TOP_BIT = {1'b1, {(IRQ_CH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;
  bus_state_t state;

  logic [IRQ_CH-1:0] s1, s2, s3;
  logic [IRQ_CH-1:0] pend, mask, edge_sel;

  logic              access, wr_en;
  logic              wr_pend, wr_mask, wr_edge, wr_set;
  logic [IRQ_CH-1:0] wr_bits;
  logic [IRQ_CH-1:0] ext_en;
  logic [IRQ_CH-1:0] level_set, event_set, clr_bits;
  logic [IRQ_CH-1:0] timer_set, cmp_clr;
  logic [IRQ_CH-1:0] pend_next, mask_next, irq_next;
  logic [2:0]        id_next;
  logic [DATA_W-1:0] rd_next;
  logic              unused_wr_bits;

  // The access executes in the single cycle where the FSM is idle and sees req.
  assign access  = (state == ST_IDLE) && bus_req;
  assign wr_en   = access && bus_rw;
  assign wr_bits = bus_wr_data[IRQ_CH-1:0];
  assign wr_pend = wr_en && (bus_addr == 3'd0);
  assign wr_mask = wr_en && (bus_addr == 3'd1);
  assign wr_edge = wr_en && (bus_addr == 3'd2);
  assign wr_set  = wr_en && (bus_addr == 3'd3);

  assign unused_wr_bits = ^bus_wr_data;

`ifdef IRQ_PIC_TIMER_EN
  logic [31:0] count, compare;
  logic        timer_hit, wr_count, wr_compare;

  assign wr_count   = wr_en && (bus_addr == 3'd4);
  assign wr_compare = wr_en && (bus_addr == 3'd5);
  assign timer_hit  = (count == compare) && (compare != 32'd0);
  assign timer_set  = timer_hit ? TOP_BIT : '0;
  assign cmp_clr    = wr_compare ? TOP_BIT : '0;
  assign ext_en     = ~TOP_BIT;

  // Free-running counter; a COUNT write loads and counting resumes from there.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
    end else begin
      count <= wr_count ? 32'(bus_wr_data) : count + 32'd1;
      if (wr_compare) compare <= 32'(bus_wr_data);
    end
  end
`else
  assign timer_set = '0;
  assign cmp_clr   = '0;
  assign ext_en    = '1;
`endif

  // Level requests can be cleared by W1C (they re-arm next cycle while the
  // source stays high); edge events, SET writes and timer hits beat a clear.
  assign level_set = s2 & ~edge_sel & ext_en;
  assign event_set = (s2 & ~s3 & edge_sel & ext_en)
                   | (wr_set ? wr_bits : '0)
                   | timer_set;
  assign clr_bits  = (wr_pend ? wr_bits : '0) | cmp_clr;
  assign pend_next = ((pend | level_set) & ~clr_bits) | event_set;
  assign mask_next = wr_mask ? wr_bits : mask;
  assign irq_next  = pend_next & ~mask_next;

  // Priority encoder, channel 0 highest.
  always_comb begin
    id_next = 3'd0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (irq_next[i]) id_next = 3'(i);
    end
  end

  // Read mux; captured into bus_rd_data on the IDLE->ACK edge.
  always_comb begin
    rd_next = '0;
    case (bus_addr)
      3'd0:    rd_next = DATA_W'(pend);
      3'd1:    rd_next = DATA_W'(mask);
      3'd2:    rd_next = DATA_W'(edge_sel);
      3'd3:    rd_next = DATA_W'(s2);
`ifdef IRQ_PIC_TIMER_EN
      3'd4:    rd_next = DATA_W'(count);
      3'd5:    rd_next = DATA_W'(compare);
`endif
      default: rd_next = '0;
    endcase
  end

  // Synchroniser, interrupt state, registered outputs and bus FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      pend        <= '0;
      mask        <= '1;
      edge_sel    <= '0;
      irq         <= '0;
      irq_id      <= 3'd0;
      irq_any     <= 1'b0;
      state       <= ST_IDLE;
      bus_ack     <= 1'b0;
      bus_rd_data <= '0;
    end else begin
      s1       <= src;
      s2       <= s1;
      s3       <= s2;
      pend     <= pend_next;
      mask     <= mask_next;
      if (wr_edge) edge_sel <= wr_bits;
      irq      <= irq_next;
      irq_id   <= id_next;
      irq_any  <= |irq_next;
      case (state)
        ST_IDLE: begin
          if (bus_req) begin
            state       <= ST_ACK;
            bus_ack     <= 1'b1;
            bus_rd_data <= bus_rw ? '0 : rd_next;
          end
        end
        ST_ACK: begin
          state       <= ST_IDLE;
          bus_ack     <= 1'b0;
          bus_rd_data <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          bus_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pic.sv
// tb_irq_pic -- self-checking bench for irq_pic (IRQ_CH = 8, DATA_W = 32).
// A behavioural model built on a source delay line tracks pend/mask/edge and
// the expected read data; it is compared against the DUT every falling edge.
// Directed sequences exercise the documented scenarios, then a randomized
// phase mixes source activity with random register accesses.
// Honours IRQ_PIC_TIMER_EN the same way the design does.

module tb_irq_pic;

  localparam int IRQ_CH = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [IRQ_CH-1:0] src;
  logic              bus_req, bus_rw;
  logic [2:0]        bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_ack;
  logic [IRQ_CH-1:0] irq;
  logic [2:0]        irq_id;
  logic              irq_any;

  always #5 clk = ~clk;

  irq_pic #(.IRQ_CH(IRQ_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .src(src),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_ack(bus_ack),
    .irq(irq), .irq_id(irq_id), .irq_any(irq_any)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] lowest_id(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Reference model: h1..h3 hold the source as sampled 1..3 edges ago, so the
  // synchronised level seen by the controller is h2 and a rising edge is h2 & ~h3.
  logic [7:0]  m_pend, m_mask, m_edge, h1, h2, h3;
  logic        m_ack, m_was_read;
  logic [31:0] m_rd, m_count, m_cmp;
  logic [7:0]  lvl, evt, clr, ext;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 8'h00; m_mask = 8'hFF; m_edge = 8'h00;
      h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
      m_ack = 1'b0; m_was_read = 1'b0; m_rd = 32'd0;
      m_count = 32'd0; m_cmp = 32'd0;
    end else begin
`ifdef IRQ_PIC_TIMER_EN
      ext = 8'h7F;
`else
      ext = 8'hFF;
`endif
      lvl = h2 & ~m_edge & ext;
      evt = h2 & ~h3 & m_edge & ext;
      clr = 8'h00;
`ifdef IRQ_PIC_TIMER_EN
      if (m_count == m_cmp && m_cmp != 32'd0) evt = evt | 8'h80;
`endif
      if (bus_req && !m_ack) begin
        m_ack      = 1'b1;
        m_was_read = !bus_rw;
        m_rd       = 32'd0;
        if (!bus_rw) begin
          case (bus_addr)
            3'd0: m_rd = {24'd0, m_pend};
            3'd1: m_rd = {24'd0, m_mask};
            3'd2: m_rd = {24'd0, m_edge};
            3'd3: m_rd = {24'd0, h2};
`ifdef IRQ_PIC_TIMER_EN
            3'd4: m_rd = m_count;
            3'd5: m_rd = m_cmp;
`endif
            default: m_rd = 32'd0;
          endcase
`ifdef IRQ_PIC_TIMER_EN
          m_count = m_count + 32'd1;
`endif
        end else begin
`ifdef IRQ_PIC_TIMER_EN
          m_count = m_count + 32'd1;
`endif
          case (bus_addr)
            3'd0: clr = bus_wr_data[7:0];
            3'd3: evt = evt | bus_wr_data[7:0];
`ifdef IRQ_PIC_TIMER_EN
            3'd4: m_count = bus_wr_data;
            3'd5: clr = 8'h80;
`endif
            default: ;
          endcase
        end
        m_pend = ((m_pend | lvl) & ~clr) | evt;
        if (bus_rw && bus_addr == 3'd1) m_mask = bus_wr_data[7:0];
        if (bus_rw && bus_addr == 3'd2) m_edge = bus_wr_data[7:0];
`ifdef IRQ_PIC_TIMER_EN
        if (bus_rw && bus_addr == 3'd5) m_cmp = bus_wr_data;
`endif
      end else begin
        m_ack  = 1'b0;
        m_pend = (m_pend | lvl) | evt;
`ifdef IRQ_PIC_TIMER_EN
        m_count = m_count + 32'd1;
`endif
      end
      h3 = h2; h2 = h1; h1 = src;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("irq",     {24'd0, irq},      {24'd0, m_pend & ~m_mask});
      checkOutput("irq_id",  {29'd0, irq_id},   {29'd0, lowest_id(m_pend & ~m_mask)});
      checkOutput("irq_any", {31'd0, irq_any},  {31'd0, |(m_pend & ~m_mask)});
      checkOutput("bus_ack", {31'd0, bus_ack},  {31'd0, m_ack});
      if (m_ack && m_was_read) checkOutput("rd_data", bus_rd_data, m_rd);
    end
  end

  // Drive the sources (called at a falling edge) and let n cycles pass.
  task automatic applyStimulus(input logic [7:0] v, input int n);
    src = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_access(input logic rw, input logic [2:0] addr,
                            input logic [31:0] data, output logic [31:0] rd);
    bit seen = 1'b0;
    rd = 32'd0;
    @(negedge clk);
    bus_req = 1'b1; bus_rw = rw; bus_addr = addr; bus_wr_data = data;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (bus_ack) begin
        seen = 1'b1;
        rd   = bus_rd_data;
      end
    end
    bus_req = 1'b0;
    if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_access(1'b1, addr, data, dummy);
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] rd);
    bus_access(1'b0, addr, 32'd0, rd);
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1; src = 8'h00; bus_req = 1'b0; bus_rw = 1'b0;
    bus_addr = 3'd0; bus_wr_data = 32'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset state and level latching behind the mask
    checkOutput("rst_irq", {24'd0, irq}, 32'h00);
    checkOutput("rst_ack", {31'd0, bus_ack}, 32'h0);
    bus_read(3'd1, rd);
    checkOutput("rst_mask", rd, 32'hFF);
    applyStimulus(8'h04, 5);
    bus_read(3'd0, rd);
    checkOutput("lvl_pend", rd, 32'h04);
    checkOutput("lvl_masked_irq", {24'd0, irq}, 32'h00);

    // Edge channel 0: one-cycle pulse reaches irq three cycles later
    applyStimulus(8'h00, 4);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd2, 32'h01);
    bus_write(3'd1, 32'h00);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h00, 2);
    checkOutput("edge_irq", {24'd0, irq}, 32'h01);
    checkOutput("edge_id", {29'd0, irq_id}, 32'd0);
    bus_write(3'd0, 32'h01);
    checkOutput("edge_w1c_irq", {24'd0, irq}, 32'h00);

    // Level re-arm on channel 2
    applyStimulus(8'h04, 4);
    checkOutput("rearm_pre", {24'd0, irq}, 32'h04);
    bus_write(3'd0, 32'h04);
    checkOutput("rearm_cleared", {24'd0, irq}, 32'h00);
    applyStimulus(8'h04, 1);
    checkOutput("rearm_irq", {24'd0, irq}, 32'h04);
    checkOutput("rearm_id", {29'd0, irq_id}, 32'd2);

    // Collision: ch1 edge event in the same cycle as W1C 0x02
    applyStimulus(8'h00, 4);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd2, 32'h02);
    applyStimulus(8'h02, 1);
    bus_write(3'd0, 32'h02);
    bus_read(3'd0, rd);
    checkOutput("collide_pend", rd, 32'h02);

    // Priority encoding
    applyStimulus(8'h00, 4);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h28);
    checkOutput("prio_irq", {24'd0, irq}, 32'h28);
    checkOutput("prio_id3", {29'd0, irq_id}, 32'd3);
    bus_write(3'd0, 32'h08);
    checkOutput("prio_id5", {29'd0, irq_id}, 32'd5);
    bus_write(3'd0, 32'hFF);

`ifdef IRQ_PIC_TIMER_EN
    bus_write(3'd4, 32'd0);
    bus_write(3'd5, 32'd10);
    applyStimulus(8'h00, 12);
    bus_read(3'd0, rd);
    checkOutput("timer_pend", rd, 32'h80);
    bus_write(3'd5, 32'd10);
    checkOutput("timer_cmp_clr", {24'd0, irq}, 32'h00);
`else
    bus_read(3'd4, rd);
    checkOutput("count_absent", rd, 32'd0);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    checkOutput("addr6_zero", rd, 32'd0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 250; k++) begin
      logic [7:0] sv;
      sv = 8'($urandom) & 8'($urandom);
      applyStimulus(sv, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) != 0) begin
        logic [2:0]  a;
        logic [31:0] d;
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        if (a == 3'd1) d = d & $urandom;
        if ($urandom_range(0, 1) == 0) bus_read(a, rd);
        else bus_write(a, d);
      end
    end

    // Reset while a request is pending: no ack, registers back to defaults
    @(negedge clk);
    bus_req = 1'b1; bus_rw = 1'b0; bus_addr = 3'd1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst2_ack", {31'd0, bus_ack}, 32'h0);
    checkOutput("rst2_irq", {24'd0, irq}, 32'h00);
    bus_req = 1'b0;
    reset = 1'b0;
    bus_read(3'd1, rd);
    checkOutput("rst2_mask", rd, 32'hFF);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
